// File: rtl/motion_bbox_detect_pkg.sv
// Shared types for the motion bounding-box producer and the box-overlay consumer.
package motion_bbox_detect_pkg;

  localparam int COORD_W = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic               flag;
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] bottom;
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] right;
  } box_t;

endpackage

// File: rtl/motion_bbox_detect_edge.sv
// Registered rising/falling edge detector for a single-bit synchronous strobe.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_d;

  always_ff @(posedge clk) begin
    if (rst) r_d <= 1'b0;
    else     r_d <= i_sig;
  end

  assign o_rise = i_sig & ~r_d;
  assign o_fall = ~i_sig & r_d;

endmodule

// File: rtl/motion_bbox_detect.sv
// Tracks min/max row/column of foreground mask pixels per frame and
// publishes the bounding box (or an empty box) at each vsync rising edge.
module motion_bbox_detect
  import motion_bbox_detect_pkg::*;
#(
  parameter int IMG_W       = 1280,
  parameter int IMG_H       = 720,
  parameter int MIN_PIX_CNT = 32,
  parameter int CNT_W       = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pre_img_vsync,
  input  logic               pre_img_hsync,
  input  logic               pre_img_valid,
  input  logic               pre_img_bit,
  output logic               box_flag,
  output logic [COORD_W-1:0] top_edge,
  output logic [COORD_W-1:0] bottom_edge,
  output logic [COORD_W-1:0] left_edge,
  output logic [COORD_W-1:0] right_edge,
  output logic               box_update
);

  localparam logic [COORD_W-1:0] W_LIM   = COORD_W'(IMG_W);
  localparam logic [COORD_W-1:0] H_LIM   = COORD_W'(IMG_H);
  localparam logic [COORD_W-1:0] X_INIT  = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_INIT  = COORD_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_MIN = CNT_W'(MIN_PIX_CNT);

  logic w_vs_rise, w_vs_fall, w_val_rise, w_val_fall;
  logic w_unused;

  sync_edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (pre_img_vsync),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  sync_edge_det u_val_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (pre_img_valid),
    .o_rise (w_val_rise),
    .o_fall (w_val_fall)
  );

  assign w_unused = &{1'b0, pre_img_hsync, w_vs_fall, w_val_rise};

  state_t             r_state;
  logic [COORD_W-1:0] r_x_cnt, r_y_cnt;
  logic [COORD_W-1:0] r_min_x, r_max_x, r_min_y, r_max_y;
  logic [CNT_W-1:0]   r_pix_cnt;
  box_t               r_box;
  logic               r_update;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else begin
      // A valid pixel in the vsync-rise cycle is column 0 of the new frame.
      if (w_vs_rise)                          r_x_cnt <= {{(COORD_W-1){1'b0}}, pre_img_valid};
      else if (w_val_fall)                    r_x_cnt <= '0;
      else if (pre_img_valid && r_x_cnt != W_LIM) r_x_cnt <= r_x_cnt + 1'b1;

      if (w_vs_rise)                          r_y_cnt <= '0;
      else if (w_val_fall && r_y_cnt != H_LIM) r_y_cnt <= r_y_cnt + 1'b1;
    end
  end

  logic [COORD_W-1:0] w_x, w_y;
  logic               w_hit, w_acc_en;
  logic [COORD_W-1:0] w_min_x, w_max_x, w_min_y, w_max_y;
  logic [CNT_W-1:0]   w_pix_cnt;

  assign w_x   = w_vs_rise ? '0 : r_x_cnt;
  assign w_y   = w_vs_rise ? '0 : r_y_cnt;
  assign w_hit = pre_img_valid & pre_img_bit & (w_x < W_LIM) & (w_y < H_LIM);

  // Accumulators restart from init on every vsync rise (after the commit has
  // sampled the old values) so the coincident pixel lands in the new frame.
  always_comb begin
    w_min_x   = r_min_x;
    w_max_x   = r_max_x;
    w_min_y   = r_min_y;
    w_max_y   = r_max_y;
    w_pix_cnt = r_pix_cnt;
    if (w_vs_rise || r_state == IDLE) begin
      w_min_x   = X_INIT;
      w_max_x   = '0;
      w_min_y   = Y_INIT;
      w_max_y   = '0;
      w_pix_cnt = '0;
    end
    w_acc_en = w_hit && (r_state == ACCUM || w_vs_rise);
    if (w_acc_en) begin
      if (w_x < w_min_x) w_min_x = w_x;
      if (w_x > w_max_x) w_max_x = w_x;
      if (w_y < w_min_y) w_min_y = w_y;
      if (w_y > w_max_y) w_max_y = w_y;
      if (w_pix_cnt != CNT_MAX) w_pix_cnt = w_pix_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_min_x   <= X_INIT;
      r_max_x   <= '0;
      r_min_y   <= Y_INIT;
      r_max_y   <= '0;
      r_pix_cnt <= '0;
    end else begin
      if (w_vs_rise) r_state <= ACCUM;
      r_min_x   <= w_min_x;
      r_max_x   <= w_max_x;
      r_min_y   <= w_min_y;
      r_max_y   <= w_max_y;
      r_pix_cnt <= w_pix_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_box    <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= w_vs_rise && (r_state == ACCUM);
      if (w_vs_rise && r_state == ACCUM) begin
        if (r_pix_cnt >= CNT_MIN) begin
          r_box.flag   <= 1'b1;
          r_box.top    <= r_min_y;
          r_box.bottom <= r_max_y;
          r_box.left   <= r_min_x;
          r_box.right  <= r_max_x;
        end else begin
          r_box <= '0;
        end
      end
    end
  end

  assign box_flag    = r_box.flag;
  assign top_edge    = r_box.top;
  assign bottom_edge = r_box.bottom;
  assign left_edge   = r_box.left;
  assign right_edge  = r_box.right;
  assign box_update  = r_update;

endmodule
